// File: rtl/cla_pkg.sv
// cla_pkg: shared sizing helpers, mode encoding and per-bank control record for the pipelined CLA.
package cla_pkg;
  localparam logic CLA_ADD = 1'b0;
  localparam logic CLA_SUB = 1'b1;
  function automatic int SLICE_W(input int width, input int nstage);
    return width / nstage;
  endfunction
  function automatic int NGRP(input int slice, input int block);
    return slice / block;
  endfunction
  typedef struct packed {
    logic v;
    logic c;
  } cla_ctl_t;
endpackage

// File: rtl/cla_blk.sv
// cla_blk: one B-bit generate/propagate lookahead group; every carry is a flat sum of products of g, p and cin.
module cla_blk #(
  parameter int B = 4
) (
  input  logic [B-1:0] x,
  input  logic [B-1:0] y,
  input  logic         cin,
  output logic [B-1:0] s,
  output logic         cout
);
  logic [B-1:0] w_g, w_p;
  logic [B:0]   w_c;
  function automatic logic [B-1:0] lo(input int n);
    lo = '0;
    for (int m = 0; m < B; m++) lo[m] = (m < n);
  endfunction
  assign w_g = x & y;
  assign w_p = x ^ y;
  // c[i] = cin&p[i-1:0] | OR_j g[j]&p[i-1:j+1]; masks select each propagate run
  always_comb begin
    w_c = '0;
    for (int i = 0; i <= B; i++) begin
      w_c[i] = cin & (&(w_p | ~lo(i)));
      for (int j = 0; j < i; j++) w_c[i] = w_c[i] | (w_g[j] & (&(w_p | ~(lo(i) & ~lo(j + 1)))));
    end
  end
  assign s    = w_p ^ w_c[B-1:0];
  assign cout = w_c[B];
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA adder/subtractor, one slice per stage, global-stall valid/ready.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder import cla_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int NSTAGE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int SW = SLICE_W(WIDTH, NSTAGE);
  localparam int NG = NGRP(SW, BLOCK);
  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;
  for (genvar k = 0; k < NSTAGE; k++) begin : g_st
    localparam int OW = (NSTAGE - k) * SW;
    logic [OW-1:0]         w_a, w_b;
    logic [(k+1)*SW-1:0]   w_ns, r_s;
    logic [SW-1:0]         w_sl;
    logic [NG:0]           w_gc;
    cla_ctl_t              w_ctl, r_ctl;
    if (k == 0) begin : g_in
      assign w_a   = x;
      assign w_b   = (sub == CLA_SUB) ? ~y : y;
      assign w_ctl = '{v: in_valid, c: (sub == CLA_SUB) ? 1'b1 : cin};
      assign w_ns  = w_sl;
    end else begin : g_mid
      assign w_a   = g_st[k-1].g_op.r_a;
      assign w_b   = g_st[k-1].g_op.r_b;
      assign w_ctl = g_st[k-1].r_ctl;
      assign w_ns  = {w_sl, g_st[k-1].r_s};
    end
    assign w_gc[0] = w_ctl.c;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_blk #(.B(BLOCK)) u_blk (
        .x   (w_a[g*BLOCK +: BLOCK]),
        .y   (w_b[g*BLOCK +: BLOCK]),
        .cin (w_gc[g]),
        .s   (w_sl[g*BLOCK +: BLOCK]),
        .cout(w_gc[g+1])
      );
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s   <= '0;
        r_ctl <= '0;
      end else if (w_adv) begin
        r_s   <= w_ns;
        r_ctl <= '{v: w_ctl.v, c: w_gc[NG]};
      end
    end
    // only the slices not yet summed travel on to later banks
    if (k < NSTAGE - 1) begin : g_op
      logic [OW-SW-1:0] r_a, r_b;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[OW-1:SW];
          r_b <= w_b[OW-1:SW];
        end
      end
    end
  end
  assign out_valid = g_st[NSTAGE-1].r_ctl.v;
  assign cout      = g_st[NSTAGE-1].r_ctl.c;
  assign sum       = g_st[NSTAGE-1].r_s;
`ifdef CLA_PIPE_OVF_EN
  logic w_ovf, r_ovf;
  // carry into the MSB recovered as a^b^s at that bit
  assign w_ovf = g_st[NSTAGE-1].w_a[SW-1] ^ g_st[NSTAGE-1].w_b[SW-1] ^ g_st[NSTAGE-1].w_sl[SW-1] ^ g_st[NSTAGE-1].w_gc[NG];
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_ovf;
  end
  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for cla_pipe_adder (32-bit, BLOCK 4, NSTAGE 4) with directed vectors.
module tb_cla_pipe_adder;
  localparam int W = 32;
  localparam int N = 4;
  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] x = '0, y = '0, sum;
  logic         in_ready, out_valid, cout;
`ifdef CLA_PIPE_OVF_EN
  logic         ovf;
`endif
  typedef struct {logic [W-1:0] x, y; logic cin, sub; logic [W-1:0] s; logic c, o;} vec_t;
  typedef struct {logic [W-1:0] s; logic c, o; int t; bit lat;} exp_t;
  vec_t dir[$], str[$];
  exp_t q[$];
  int   errors = 0, checks = 0, edges = 0;
  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .NSTAGE(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  function automatic vec_t mk(input logic [W-1:0] a, b, input logic ci, sb, input logic [W-1:0] s, input logic c, o);
    vec_t v;
    v.x = a; v.y = b; v.cin = ci; v.sub = sb; v.s = s; v.c = c; v.o = o;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask
  task automatic send(input vec_t v, input bit lat);
    int n = 0;
    x = v.x; y = v.y; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    q.push_back('{s: v.s, c: v.c, o: v.o, t: edges, lat: lat});
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      chk("result_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef CLA_PIPE_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.o));
`endif
        if (e.lat) chk("latency", 64'(edges - e.t), 64'(N - 1));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] hs;
    logic         hc;
    dir.push_back(mk(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0));
    dir.push_back(mk(32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0));
    dir.push_back(mk(32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0));
    dir.push_back(mk(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1));
    dir.push_back(mk(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1));
    str.push_back(mk(32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0));
    str.push_back(mk(32'h0000000F, 32'h00000001, 0, 0, 32'h00000010, 0, 0));
    str.push_back(mk(32'h000000FF, 32'h00000001, 1, 0, 32'h00000101, 0, 0));
    str.push_back(mk(32'hFFFF0000, 32'h00010000, 0, 0, 32'h00000000, 1, 0));
    str.push_back(mk(32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0));
    str.push_back(mk(32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1));
    str.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0));
    str.push_back(mk(32'h00000000, 32'h00000000, 1, 0, 32'h00000001, 0, 0));
    str.push_back(mk(32'h00000010, 32'h00000001, 0, 1, 32'h0000000F, 1, 0));
    str.push_back(mk(32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0));
    str.push_back(mk(32'h12345678, 32'h12345678, 0, 1, 32'h00000000, 1, 0));
    str.push_back(mk(32'h00000001, 32'hFFFFFFFF, 0, 1, 32'h00000002, 0, 0));
    str.push_back(mk(32'h00000064, 32'h00000032, 1, 1, 32'h00000032, 1, 0));
    str.push_back(mk(32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, 32'hFFFFFFFF, 0, 0));
    str.push_back(mk(32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 32'h00000000, 1, 0));
    str.push_back(mk(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CLA_PIPE_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk);
    #1;
    foreach (dir[i]) send(dir[i], 1'b1);
    drain();
    @(posedge clk);
    #1;
    fork
      begin
        foreach (str[i]) send(str[i], 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hs = sum;
        hc = cout;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (2) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("hold_sum", 64'(sum), 64'(hs));
          chk("hold_cout", 64'(cout), 64'(hc));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(str[i], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(dir[0], 1'b1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the fixed-width combinational CLA blocks: WIDTH and BLOCK size are configurable, the carry chain is split across NSTAGE register stages, and it adds add/sub mode plus a valid/ready stream handshake with backpressure. It is the wide-operand adder for the Karatsuba combine stage and the CSLA replacement in 32/64-bit multipliers.

Parameters:
WIDTH, 32, operand/sum width in bits
BLOCK, 4, bits per lookahead group (2..7)
NSTAGE, 4, pipeline stages; latency in cycles; WIDTH % NSTAGE == 0 and (WIDTH/NSTAGE) % BLOCK == 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands present
in_ready  out  1  block accepts operands this cycle
x  in  WIDTH  operand A
y  in  WIDTH  operand B
cin  in  1  carry-in (add mode only)
sub  in  1  0: x+y+cin; 1: x-y (two's complement)
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB (sub: 1 = no borrow)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- SLICE = WIDTH/NSTAGE. Register banks R1..RNSTAGE.
  - Ri holds: sum slices 0..i-1, carry out of slice i-1, unconsumed operand slices i..N-1, and valid bit vi.
  - Slice k is computed combinationally from R(k) (from the inputs for k=0) by SLICE/BLOCK cla_blk groups in ripple-of-lookahead order, then registered into R(k+1).
- Sub mode:
  - y is bitwise inverted at input.
  - Effective carry-in is 1; cin is ignored.
- Advance: adv = ~out_valid | out_ready. It is a global stall: all banks load only when adv=1.
  - in_ready = adv (combinational). A transfer occurs on in_valid & in_ready.
  - v1 loads in_valid & in_ready. Each vi+1 loads vi.
- out_valid = vNSTAGE. sum and cout are driven from RNSTAGE.
  - Held stable while out_valid & ~out_ready.
- Latency:
  - Operands accepted at edge t appear with out_valid=1 after edge t+NSTAGE-1, i.e. visible in cycle t+NSTAGE.
  - Throughput is one result per cycle when unstalled.
- Bubbles (in_valid=0) propagate as invalid slots. Invalid slots are overwritten freely.
- Reset:
  - All vi=0, all data registers 0, so out_valid=0, sum=0, cout=0. in_ready=1 in the cycle after reset.
  - Reset mid-stream discards every in-flight operation; no partial result is emitted.
- Wrap-around: the sum is modulo 2^WIDTH, with the carry reported in cout.
- Simultaneous events:
  - An accept and an emit in the same cycle are both honoured.
  - rst overrides all.
- NSTAGE=1 degenerates to a single registered CLA with latency 1.

Optional Feature:
Macro CLA_PIPE_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed overflow of the final result, = carry into MSB XOR cout. It is pipelined alongside sum, reset to 0, and held under stall.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Package cla_pkg:
  - localparam helpers SLICE_W(WIDTH,NSTAGE) and NGRP(SLICE,BLOCK).
  - Stage-record typedef for sum/carry/operand/valid fields.
  - Mode encoding constants CLA_ADD=0 and CLA_SUB=1.
- Sub-module cla_blk: parametrised BLOCK-bit generate/propagate lookahead group with inputs x, y, cin and outputs s, cout. It is instantiated NSTAGE*SLICE/BLOCK times via generate.

Test Plan:
- WIDTH=32, BLOCK=4, NSTAGE=4; x=0xFFFFFFFF, y=0x00000001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x00000000, cout=1 (carry crosses every slice).
- sub=1, x=5, y=7 -> sum=0xFFFFFFFE, cout=0. Then x=7, y=5 -> sum=0x00000002, cout=1.
- Stream 16 random pairs back-to-back with out_ready=1 -> 16 results in order, one per cycle, first at cycle 4, all matching the reference model.
- Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, sum/cout held constant, then results resume with no loss or duplication.
- Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 next cycle, sum=0, no stale result ever emitted, in_ready=1.
- With CLA_PIPE_OVF_EN: x=0x7FFFFFFF, y=1, add -> ovf=1, sum=0x80000000. x=0x80000000, y=1, sub -> ovf=1. Without the macro the bench compiles with no ovf port.
